// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-to-binary decoders.
package sc_pkg;

  localparam int unsigned SC_FN_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    WAIT = 2'd2
  } sc_bs2bin_state_t;

  // Scale a window count up to data_w bits; a full window saturates to all ones.
  function automatic logic [SC_FN_W-1:0] sc_scale_cnt(
    input logic [SC_FN_W-1:0] ones,
    input int unsigned        win_log2,
    input int unsigned        data_w
  );
    logic [SC_FN_W-1:0] full;
    full = SC_FN_W'(1) << win_log2;
    if (ones >= full) begin
      return (SC_FN_W'(1) << data_w) - SC_FN_W'(1);
    end
    return ones << (data_w - win_log2);
  endfunction

endpackage

// File: rtl/sc_win_cnt.sv
// Enable-qualified window counter: tick counts enabled edges, ones counts 1s seen.
module sc_win_cnt #(
  parameter int unsigned WIN_LOG2 = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              bit_in,
  output logic [WIN_LOG2:0] ones,
  output logic              last
);

  localparam int unsigned CNT_W = WIN_LOG2 + 1;
  localparam logic [WIN_LOG2-1:0] TICK_MAX = '1;

  logic [WIN_LOG2-1:0] tick;

  // High on the enabled edge that carries the final bit of the window.
  assign last = en && (tick == TICK_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones <= '0;
      tick <= '0;
    end else if (clr) begin
      ones <= '0;
      tick <= '0;
    end else if (en) begin
      ones <= ones + CNT_W'(bit_in);
      tick <= tick + WIN_LOG2'(1);
    end
  end

endmodule

// File: rtl/sc_uni_bs2bin.sv
// Unipolar bitstream-to-binary decoder with valid/ready output and a stall (WAIT) holding slot.
module sc_uni_bs2bin
  import sc_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned WIN_LOG2 = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cont,
  input  logic              enable,
  input  logic              iBit,
  output logic [DATA_W-1:0] oData,
  output logic              oValid,
  input  logic              iReady,
  output logic              busy
);

  localparam int unsigned CNT_W = WIN_LOG2 + 1;

  sc_bs2bin_state_t state, state_n;

  logic [CNT_W-1:0]  ones;
  logic [CNT_W-1:0]  final_cnt;
  logic [CNT_W-1:0]  hold_q, hold_n;
  logic [CNT_W-1:0]  load_cnt;
  logic [DATA_W-1:0] load_data;
  logic              cnt_en;
  logic              cnt_clr;
  logic              last;
  logic              slot_free;
  logic              load;

  assign cnt_en    = (state == ACC) && enable;
  assign final_cnt = ones + CNT_W'(iBit);
  assign slot_free = !oValid || iReady;
  assign load_data = DATA_W'(sc_scale_cnt(SC_FN_W'(load_cnt), WIN_LOG2, DATA_W));

  sc_win_cnt #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_win_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .bit_in (iBit),
    .ones   (ones),
    .last   (last)
  );

  // Next-state, counter clear and output-slot load decisions.
  always_comb begin
    state_n  = state;
    hold_n   = hold_q;
    cnt_clr  = 1'b0;
    load     = 1'b0;
    load_cnt = final_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = ACC;
          cnt_clr = 1'b1;
        end
      end
      ACC: begin
        if (last) begin
          cnt_clr = 1'b1;
          if (slot_free) begin
            load    = 1'b1;
            state_n = cont ? ACC : IDLE;
          end else begin
            hold_n  = final_cnt;
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (slot_free) begin
          load     = 1'b1;
          load_cnt = hold_q;
          cnt_clr  = 1'b1;
          state_n  = cont ? ACC : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      hold_q <= '0;
      oData  <= '0;
      oValid <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      hold_q <= hold_n;
      busy   <= (state_n != IDLE);
      if (load) begin
        oData  <= load_data;
        oValid <= 1'b1;
      end else if (iReady) begin
        oValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sc_uni_bs2bin.sv
// Directed self-checking bench for sc_uni_bs2bin (8-bit window and 6-bit window variants).
module tb_sc_uni_bs2bin;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       start6;
  logic       cont;
  logic       enable;
  logic       iBit;
  logic       iReady;
  logic [7:0] oData;
  logic       oValid;
  logic       busy;
  logic [7:0] oData6;
  logic       oValid6;
  logic       busy6;

  int checks   = 0;
  int failures = 0;

  sc_uni_bs2bin #(.DATA_W(8), .WIN_LOG2(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .cont   (cont),
    .enable (enable),
    .iBit   (iBit),
    .oData  (oData),
    .oValid (oValid),
    .iReady (iReady),
    .busy   (busy)
  );

  sc_uni_bs2bin #(.DATA_W(8), .WIN_LOG2(6)) dut6 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start6),
    .cont   (cont),
    .enable (enable),
    .iBit   (iBit),
    .oData  (oData6),
    .oValid (oValid6),
    .iReady (iReady),
    .busy   (busy6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // First Sobol dimension over a 256-point period is the bit-reversed index.
  function automatic logic [7:0] sobol8(input int idx);
    logic [7:0] v;
    logic [7:0] r;
    v = 8'(idx);
    for (int b = 0; b < 8; b++) r[b] = v[7-b];
    return r;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; start = 0; start6 = 0; cont = 0; enable = 0; iBit = 0; iReady = 1;
    #12;
    checks++; if (oData !== 8'd0) begin failures++; $display("FAIL reset_odata got=%0d exp=0", oData); end
    checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL reset_ovalid got=%b exp=0", oValid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    step;
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_const_ones;
    start = 1; step; start = 0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL const_busy_rise got=%b exp=1", busy); end
    enable = 1; iBit = 1;
    for (int i = 0; i < 256; i++) begin
      step;
      if (i == 254) begin
        checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL const_early_valid got=%b exp=0", oValid); end
      end
    end
    checks++; if (oValid !== 1'b1) begin failures++; $display("FAIL const_valid got=%b exp=1", oValid); end
    checks++; if (oData !== 8'd255) begin failures++; $display("FAIL const_sat got=%0d exp=255", oData); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL const_busy_fall got=%b exp=0", busy); end
    enable = 0; iBit = 0;
    step;
    checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL const_consume got=%b exp=0", oValid); end
  endtask

  task automatic test_sobol(input int v);
    start = 1; step; start = 0; enable = 1;
    for (int i = 0; i < 256; i++) begin
      iBit = (8'(v) > sobol8(i));
      step;
      if (i == 254) begin
        checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL sobol%0d_early got=%b exp=0", v, oValid); end
      end
    end
    checks++; if (oValid !== 1'b1) begin failures++; $display("FAIL sobol%0d_valid got=%b exp=1", v, oValid); end
    checks++; if (oData !== 8'(v)) begin failures++; $display("FAIL sobol%0d_data got=%0d exp=%0d", v, oData, v); end
    enable = 0; iBit = 0;
    step;
  endtask

  task automatic test_enable_toggle;
    start = 1; step; start = 0;
    for (int k = 0; k < 512; k++) begin
      if (k % 2 == 1) begin
        enable = 1; iBit = (8'd100 > sobol8(k / 2));
      end else begin
        enable = 0; iBit = 1;
      end
      step;
      if (k == 510) begin
        checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL toggle_early got=%b exp=0", oValid); end
      end
    end
    checks++; if (oValid !== 1'b1) begin failures++; $display("FAIL toggle_valid got=%b exp=1", oValid); end
    checks++; if (oData !== 8'd100) begin failures++; $display("FAIL toggle_data got=%0d exp=100", oData); end
    enable = 0; iBit = 0;
    step;
  endtask

  task automatic test_back_to_back;
    iReady = 0; cont = 1;
    start = 1; step; start = 0; enable = 1;
    for (int i = 0; i < 512; i++) begin
      iBit = i[0];
      step;
      if (i == 255) begin
        checks++; if (oValid !== 1'b1 || oData !== 8'd128) begin failures++; $display("FAIL b2b_first got=%b/%0d exp=1/128", oValid, oData); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_cont_busy got=%b exp=1", busy); end
      end
    end
    iBit = 1;
    for (int i = 0; i < 4; i++) step;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_wait_busy got=%b exp=1", busy); end
    checks++; if (oValid !== 1'b1 || oData !== 8'd128) begin failures++; $display("FAIL b2b_wait_hold got=%b/%0d exp=1/128", oValid, oData); end
    iReady = 1;
    step;
    checks++; if (oValid !== 1'b1 || oData !== 8'd128) begin failures++; $display("FAIL b2b_second got=%b/%0d exp=1/128", oValid, oData); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_resume_busy got=%b exp=1", busy); end
    cont = 0;
    for (int j = 0; j < 256; j++) begin
      iBit = (j < 64);
      step;
      if (j == 254) begin
        checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL b2b_third_early got=%b exp=0", oValid); end
      end
    end
    checks++; if (oValid !== 1'b1 || oData !== 8'd64) begin failures++; $display("FAIL b2b_third got=%b/%0d exp=1/64", oValid, oData); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_busy got=%b exp=0", busy); end
    enable = 0; iBit = 0;
    step;
  endtask

  task automatic test_win6(input int n_ones, input logic [7:0] exp);
    start6 = 1; step; start6 = 0; enable = 1;
    for (int i = 0; i < 64; i++) begin
      iBit = (i < n_ones);
      step;
    end
    checks++; if (oValid6 !== 1'b1) begin failures++; $display("FAIL win6_%0d_valid got=%b exp=1", n_ones, oValid6); end
    checks++; if (oData6 !== exp) begin failures++; $display("FAIL win6_%0d_data got=%0d exp=%0d", n_ones, oData6, exp); end
    enable = 0; iBit = 0;
    step;
  endtask

  task automatic test_reset_mid;
    start = 1; step; start = 0; enable = 1; iBit = 1;
    for (int i = 0; i < 100; i++) step;
    start = 1; step; start = 0;
    rst_n = 1'b0;
    #1;
    checks++; if (oValid !== 1'b0 || oData !== 8'd0) begin failures++; $display("FAIL mid_reset_out got=%b/%0d exp=0/0", oValid, oData); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
    enable = 0; iBit = 0;
    step;
    rst_n = 1'b1;
    step;
    test_sobol(100);
  endtask

  initial begin
    test_reset;
    test_const_ones;
    test_sobol(100);
    test_sobol(0);
    test_sobol(255);
    test_enable_toggle;
    test_back_to_back;
    test_win6(32, 8'd128);
    test_win6(64, 8'd255);
    test_win6(0, 8'd0);
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
